// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter for the CPU memory bus.
// Grants last a whole strobe/ack transaction; a watchdog terminates unacknowledged strobes.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o
);

    localparam logic       WdEn     = (TIMEOUT != 0);
    localparam logic [7:0] WdLimit  = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StErr} state_e;

    state_e      state_q;
    logic [1:0]  grant_q;
    logic        last_q;   // 0: m0 was granted last, 1: m1
    logic        owner_q;  // owner of the terminated transaction while in StErr
    logic [7:0]  cnt_q;
    logic        own_stb;

    assign own_stb = (state_q == StGrant1) ? m1_stb_i :
                     (state_q == StGrant0) ? m0_stb_i :
                     (owner_q ? m1_stb_i : m0_stb_i);
    assign grant_o = grant_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= 8'd0;
                    if (m0_stb_i && (!m1_stb_i || last_q)) begin
                        state_q <= StGrant0;
                        grant_q <= 2'b01;
                    end else if (m1_stb_i) begin
                        state_q <= StGrant1;
                        grant_q <= 2'b10;
                    end
                end
                StGrant0, StGrant1: begin
                    if (!own_stb && !s_ack_i) begin
                        state_q <= StIdle;
                        grant_q <= 2'b00;
                        last_q  <= (state_q == StGrant1);
                        cnt_q   <= 8'd0;
                    end else if (s_ack_i) begin
                        // Ack beats a simultaneous watchdog expiry.
                        cnt_q <= 8'd0;
                    end else if (WdEn && cnt_q == WdLimit) begin
                        state_q <= StErr;
                        owner_q <= (state_q == StGrant1);
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StErr: begin
                    if (!own_stb) begin
                        state_q <= StIdle;
                        grant_q <= 2'b00;
                        last_q  <= owner_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        s_sel_o  = 4'd0;
        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state_q)
            StGrant0: begin
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
            end
            StGrant1: begin
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
            end
            StErr: begin
                m0_ack_o = !owner_q;
                m0_err_o = !owner_q;
                m1_ack_o = owner_q;
                m1_err_o = owner_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed table-driven bench for bus_arbiter (TIMEOUT=4) plus a TIMEOUT=0 watchdog-off copy.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_stb = 1'b0, m1_stb = 1'b0, s_ack = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b1;
    logic [31:0] m0_adr = 32'h100, m1_adr = 32'h200;
    logic [31:0] m0_dat = 32'h1111_1111, m1_dat = 32'h2222_2222;
    logic [3:0]  m0_sel = 4'hF, m1_sel = 4'b0011;
    logic [31:0] s_dat_in = 32'd0;

    logic [31:0] m0_rd, m1_rd, s_adr, s_wd;
    logic        m0_ack, m1_ack, m0_err, m1_err, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    logic [31:0] z_m0_rd, z_m1_rd, z_s_adr, z_s_wd;
    logic        z_m0_ack, z_m1_ack, z_m0_err, z_m1_err, z_s_stb, z_s_we;
    logic [3:0]  z_s_sel;
    logic [1:0]  z_grant;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(4)) u_dut (
        .clk(clk), .rst_ni(rst_ni),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_sel_i(m0_sel), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_sel_i(m1_sel), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wd), .s_sel_o(s_sel),
        .s_dat_i(s_dat_in), .s_ack_i(s_ack), .grant_o(grant)
    );

    bus_arbiter #(.TIMEOUT(0)) u_dut_nowd (
        .clk(clk), .rst_ni(rst_ni),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_sel_i(m0_sel), .m0_dat_o(z_m0_rd), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_sel_i(m1_sel), .m1_dat_o(z_m1_rd), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
        .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_adr_o(z_s_adr), .s_dat_o(z_s_wd),
        .s_sel_o(z_s_sel), .s_dat_i(s_dat_in), .s_ack_i(s_ack), .grant_o(z_grant)
    );

    // route: 0 = slave port and read data idle, 1 = m0 connected, 2 = m1 connected
    typedef struct {
        logic       m0s, m1s, ack;
        logic [1:0] grant, route;
        logic       sstb;
        logic [1:0] acks, errs;
    } vec_t;

    function automatic vec_t mk(input logic m0s, input logic m1s, input logic ack,
                                input logic [1:0] grant, input logic [1:0] route,
                                input logic sstb, input logic [1:0] acks,
                                input logic [1:0] errs);
        vec_t v;
        v.m0s = m0s; v.m1s = m1s; v.ack = ack; v.grant = grant; v.route = route;
        v.sstb = sstb; v.acks = acks; v.errs = errs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " grant"}, 32'(grant), 32'd0);
        check({tag, " s_stb"}, 32'(s_stb), 32'd0);
        check({tag, " s_adr"}, s_adr, 32'd0);
        check({tag, " s_sel/we"}, {27'd0, s_sel, s_we}, 32'd0);
        check({tag, " acks/errs"}, {28'd0, m1_ack, m0_ack, m1_err, m0_err}, 32'd0);
        check({tag, " rdata"}, m0_rd | m1_rd, 32'd0);
    endtask

    vec_t vecs[37];

    initial begin
        vecs[0]  = mk(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[1]  = mk(1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[2]  = mk(1, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00);
        vecs[3]  = mk(1, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00);
        vecs[4]  = mk(1, 0, 1, 2'b01, 1, 1, 2'b01, 2'b00);
        vecs[5]  = mk(0, 0, 1, 2'b01, 1, 0, 2'b01, 2'b00);
        vecs[6]  = mk(0, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00);
        vecs[7]  = mk(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[8]  = mk(1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[9]  = mk(1, 1, 1, 2'b10, 2, 1, 2'b10, 2'b00);
        vecs[10] = mk(1, 0, 0, 2'b10, 2, 0, 2'b00, 2'b00);
        vecs[11] = mk(1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[12] = mk(1, 1, 1, 2'b01, 1, 1, 2'b01, 2'b00);
        vecs[13] = mk(0, 1, 0, 2'b01, 1, 0, 2'b00, 2'b00);
        vecs[14] = mk(1, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[15] = mk(1, 1, 1, 2'b10, 2, 1, 2'b10, 2'b00);
        vecs[16] = mk(1, 0, 0, 2'b10, 2, 0, 2'b00, 2'b00);
        vecs[17] = mk(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[18] = mk(1, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        for (int i = 19; i <= 23; i++) vecs[i] = mk(1, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00);
        vecs[24] = mk(1, 0, 0, 2'b01, 0, 0, 2'b01, 2'b01);
        vecs[25] = mk(1, 0, 0, 2'b01, 0, 0, 2'b01, 2'b01);
        vecs[26] = mk(0, 0, 0, 2'b01, 0, 0, 2'b01, 2'b01);
        vecs[27] = mk(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[28] = mk(0, 0, 1, 2'b00, 0, 0, 2'b00, 2'b00);
        vecs[29] = mk(0, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
        for (int i = 30; i <= 33; i++) vecs[i] = mk(0, 1, 0, 2'b10, 2, 1, 2'b00, 2'b00);
        vecs[34] = mk(0, 1, 1, 2'b10, 2, 1, 2'b10, 2'b00);
        vecs[35] = mk(0, 0, 0, 2'b10, 2, 0, 2'b00, 2'b00);
        vecs[36] = mk(0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);

        // Reset state
        @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 37; i++) begin
            logic [31:0] e_adr, e_wd, e_m0rd, e_m1rd;
            logic [3:0]  e_sel;
            logic        e_we;
            string       tag;
            @(negedge clk);
            m0_stb   = vecs[i].m0s;
            m1_stb   = vecs[i].m1s;
            s_ack    = vecs[i].ack;
            s_dat_in = (i == 4) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
            e_adr = 32'd0; e_wd = 32'd0; e_sel = 4'd0; e_we = 1'b0;
            e_m0rd = 32'd0; e_m1rd = 32'd0;
            if (vecs[i].route == 2'd1) begin
                e_adr = 32'h100; e_wd = 32'h1111_1111; e_sel = 4'hF; e_we = 1'b0;
                e_m0rd = s_dat_in;
            end else if (vecs[i].route == 2'd2) begin
                e_adr = 32'h200; e_wd = 32'h2222_2222; e_sel = 4'b0011; e_we = 1'b1;
                e_m1rd = s_dat_in;
            end
            #1;
            tag = $sformatf("v%0d", i);
            check({tag, " grant"}, 32'(grant), 32'(vecs[i].grant));
            check({tag, " s_stb"}, 32'(s_stb), 32'(vecs[i].sstb));
            check({tag, " s_adr"}, s_adr, e_adr);
            check({tag, " s_dat"}, s_wd, e_wd);
            check({tag, " s_sel/we"}, {27'd0, s_sel, s_we}, {27'd0, e_sel, e_we});
            check({tag, " m0_dat"}, m0_rd, e_m0rd);
            check({tag, " m1_dat"}, m1_rd, e_m1rd);
            check({tag, " acks"}, {30'd0, m1_ack, m0_ack}, 32'(vecs[i].acks));
            check({tag, " errs"}, {30'd0, m1_err, m0_err}, 32'(vecs[i].errs));
            check({tag, " nowd errs"}, {30'd0, z_m1_err, z_m0_err}, 32'd0);
        end

        // Reset while m1 is granted with ack high; last is m0 beforehand.
        @(negedge clk); m0_stb = 1'b1; m1_stb = 1'b0; s_ack = 1'b0;
        @(negedge clk); s_ack = 1'b1;
        @(negedge clk); m0_stb = 1'b0; s_ack = 1'b0;
        @(negedge clk); m1_stb = 1'b1;
        @(negedge clk); s_ack = 1'b1;
        #1;
        check("pre-reset grant", 32'(grant), 32'h2);
        check("pre-reset m1_ack", 32'(m1_ack), 32'h1);
        rst_ni = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_ni = 1'b1;
        m0_stb = 1'b1; m1_stb = 1'b1; s_ack = 1'b0;
        #1;
        check("post-reset idle", 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        check("post-reset tie", 32'(grant), 32'h1);
        check("post-reset s_adr", s_adr, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the CPU's 32-bit memory bus. It lets the CPU (master 0) and a second bus master such as a DMA engine (master 1) share one slave port. Grants are round-robin and held for a whole strobe/acknowledge transaction. A watchdog terminates any transaction the slave never acknowledges, so a missing device cannot hang the processor.

## Interface
Parameters:
- TIMEOUT, 64: cycles a granted strobe may wait for `s_ack_i` before the arbiter terminates it. Legal range 1..255; 0 disables the watchdog.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- m0_stb_i, m1_stb_i  in  1  master request/strobe, held until ack seen.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_adr_i, m1_adr_i  in  32  address.
- m0_dat_i, m1_dat_i  in  32  write data.
- m0_sel_i, m1_sel_i  in  4  byte selects.
- m0_dat_o, m1_dat_o  out  32  read data: `s_dat_i` when that master owns the bus in GRANT, else 0.
- m0_ack_o, m1_ack_o  out  1  acknowledge to master.
- m0_err_o, m1_err_o  out  1  timeout error, asserted together with ack.
- s_stb_o, s_we_o  out  1  slave strobe and write enable.
- s_adr_o, s_dat_o  out  32  slave address and write data.
- s_sel_o  out  4  slave byte selects.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge (level; held until strobe drops).
- grant_o  out  2  one-hot owner, registered; 00 when idle.

## Operation
- State machine has four states: IDLE, GRANT0, GRANT1, ERR. ERR records its owner internally.
- IDLE, arbitration:
  - Only m0 requests: go to GRANT0. Only m1 requests: go to GRANT1.
  - Both request: grant the master that was not granted last.
  - `last` resets to 1, so m0 wins the first tie.
- GRANTx, slave outputs: `s_stb/we/adr/dat/sel` equal master x's inputs combinationally. The other master's inputs are ignored.
- GRANTx, return path: `mx_ack_o = s_ack_i`; the other master's ack, err and dat stay 0.
- GRANTx, release: when `mx_stb_i == 0` and `s_ack_i == 0`, go to IDLE and set `last <= x`.
- A master may drop its strobe before ack (abort). Release happens once ack is also low.
- Watchdog counter:
  - 8-bit counter, cleared on entry to GRANTx and whenever `s_ack_i` is high.
  - Increments each GRANT cycle with `mx_stb_i == 1` and `s_ack_i == 0`.
  - When it reaches TIMEOUT, go to ERR with owner x.
- ERR, owner x:
  - `s_stb_o` is forced 0.
  - `mx_ack_o = mx_err_o = 1` and `mx_dat_o = 0`.
  - When `mx_stb_i` goes 0, go to IDLE and set `last <= x`.
- Outside a granted state, all slave outputs are 0.
- A stray `s_ack_i` in IDLE is ignored: it is not routed to any master.

## Timing
- Reset (async assert, sync deassert by the system): state IDLE, `grant_o = 00`, `last = 1`, counter 0. All m*_ack/err/dat outputs and all s_* outputs are 0.
- Assertion of `rst_ni` mid-transaction drops `s_stb_o` and all acks immediately, with no completion.
- Grant latency: a request sampled in IDLE at edge N gives `grant_o` and a visible `s_stb_o` in the cycle after edge N.
- Ack to master has zero added latency: it is combinational from `s_ack_i`.
- Turnaround: at least one IDLE cycle between consecutive transactions. A waiting requester is granted on the edge after the IDLE cycle.
- Two back-to-back CPU accesses with m1 continuously requesting alternate m0, m1, m0.
- Timeout: with `s_ack_i` stuck low, `mx_ack_o`/`mx_err_o` rise TIMEOUT+1 cycles after `s_stb_o` first went high.
- With TIMEOUT=0 the counter never triggers ERR.
- Simultaneous `s_ack_i` rise and the count reaching TIMEOUT: ack wins, the counter clears and the state stays GRANT.

## Test plan
- After reset, m0 only issues a read at 0x100; slave acks after 3 cycles with 0xDEADBEEF. Required: `grant_o = 01`, `m0_dat_o = 0xDEADBEEF` with `m0_ack_o`, `m1_ack_o = 0`, return to IDLE after m0 drops stb.
- m0 and m1 both request from reset and keep re-requesting. Required: grants go m0, m1, m0, m1, each separated by exactly one IDLE cycle.
- m1 is granted and writing with sel=0011. Required: `s_sel_o = 0011` and `s_we_o = 1`; m0's concurrent request is not seen on the slave port until m1 releases.
- TIMEOUT=4, slave never acks m0. Required: `m0_ack_o = m0_err_o = 1` five cycles after the strobe, `s_stb_o = 0` from that cycle on, and IDLE once m0 drops stb.
- `rst_ni` pulsed low while in GRANT1 with ack high. Required: all outputs are 0 within the reset cycle, and after reset a tie grants m0.
- m0 drops its strobe while `s_ack_i` is high. Required: the arbiter holds GRANT0 until ack falls, then goes IDLE.
